// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module   : game_pkg
// Purpose  : Shared encodings for the racing game blocks: operation codes,
//            game-state codes, boost FSM state codes, and helpers that resolve
//            a set of direction buttons to an operation code.
//            Direction vectors use bit 0 = up, 1 = down, 2 = left, 3 = right.
// Revision : 1.0 - initial release
// ============================================================================
package game_pkg;

  // Operation codes
  localparam logic [2:0] c_OP_NIL      = 3'd0;
  localparam logic [2:0] c_OP_FORWARD  = 3'd1;
  localparam logic [2:0] c_OP_BACKWARD = 3'd2;
  localparam logic [2:0] c_OP_LEFT     = 3'd3;
  localparam logic [2:0] c_OP_RIGHT    = 3'd4;

  // Game state codes
  localparam logic [2:0] c_ST_IDLE      = 3'd0;
  localparam logic [2:0] c_ST_SETTING   = 3'd1;
  localparam logic [2:0] c_ST_COUNTDOWN = 3'd3;
  localparam logic [2:0] c_ST_RACING    = 3'd4;
  localparam logic [2:0] c_ST_PAUSE     = 3'd5;
  localparam logic [2:0] c_ST_FINISH    = 3'd6;

  // Boost FSM state codes
  localparam logic [1:0] c_BST_READY    = 2'd0;
  localparam logic [1:0] c_BST_ACTIVE   = 2'd1;
  localparam logic [1:0] c_BST_COOLDOWN = 2'd2;

  // Fixed-priority pick: FORWARD > BACKWARD > LEFT > RIGHT, NIL if empty.
  function automatic logic [2:0] pick_dir(input logic [3:0] dirs);
    logic [2:0] op;
    op = c_OP_NIL;
    if (dirs[0])      op = c_OP_FORWARD;
    else if (dirs[1]) op = c_OP_BACKWARD;
    else if (dirs[2]) op = c_OP_LEFT;
    else if (dirs[3]) op = c_OP_RIGHT;
    return op;
  endfunction

  // True when the button that produces 'op' is currently held.
  function automatic logic dir_held(input logic [2:0] op, input logic [3:0] dirs);
    logic held;
    held = 1'b0;
    case (op)
      c_OP_FORWARD:  held = dirs[0];
      c_OP_BACKWARD: held = dirs[1];
      c_OP_LEFT:     held = dirs[2];
      c_OP_RIGHT:    held = dirs[3];
      default:       held = 1'b0;
    endcase
    return held;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Purpose  : 2-flop synchronizer followed by a counter debouncer. The level
//            flips only after DEBOUNCE_CYCLES consecutive synchronized samples
//            disagree with it; any agreeing sample restarts the count.
// Ports    : clk    - system clock, rising edge
//            rst_n  - asynchronous active-low reset
//            btn    - raw asynchronous button input
//            level  - debounced level
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level
);

  localparam int c_CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(DEBOUNCE_CYCLES - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_level;
  logic [c_CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_CNT_LAST) begin
        // This sample is the last of the required disagreeing run.
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/operation_encoder.sv
`default_nettype none
// ============================================================================
// Module   : operation_encoder
// Purpose  : Turns raw direction/boost buttons into a registered operation
//            code (last-pressed direction wins) and a timed boost with
//            cooldown, gated by the game state.
// Config   : OPERATION_ENCODER_BOOST_EN - when defined, the boost path is
//            built; otherwise boost/boost_ready are tied low and btn_boost
//            is ignored.
// Ports    : clk, rst_n                  - clock / async active-low reset
//            btn_up/down/left/right      - raw direction buttons
//            btn_boost                   - raw boost button
//            state[2:0]                  - game state code
//            operation_code[2:0]         - registered operation code
//            boost                       - boost active while racing
//            boost_ready                 - boost request would be accepted
// Revision : 1.0 - initial release
// ============================================================================
module operation_encoder
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BOOST_CYCLES    = 64,
  parameter int COOLDOWN_CYCLES = 128
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_boost,
  input  logic [2:0] state,
  output logic [2:0] operation_code,
  output logic       boost,
  output logic       boost_ready
);

  // ---------------------------------------------------------------- directions
  logic [3:0] w_btn_raw;
  logic [3:0] w_lvl;
  logic [3:0] r_prev;
  logic [3:0] w_rise;
  logic [2:0] r_last;
  logic [2:0] w_track_next;
  logic [2:0] r_op;

  assign w_btn_raw = {btn_right, btn_left, btn_down, btn_up};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dir
      btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (w_btn_raw[gi]),
        .level(w_lvl[gi])
      );
    end
  endgenerate

  assign w_rise = w_lvl & ~r_prev;

  // New presses take over (simultaneous presses by priority). If the tracked
  // direction is no longer held, fall back to the best direction still held.
  // The output register is fed from the next-tracker value so a debounced
  // change costs only one more cycle.
  always_comb begin
    w_track_next = r_last;
    if (|w_rise) begin
      w_track_next = pick_dir(w_rise);
    end else if (!dir_held(r_last, w_lvl)) begin
      w_track_next = pick_dir(w_lvl);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= '0;
      r_last <= c_OP_NIL;
      r_op   <= c_OP_NIL;
    end else begin
      r_prev <= w_lvl;
      r_last <= w_track_next;
      r_op   <= (state == c_ST_RACING) ? w_track_next : c_OP_NIL;
    end
  end

  assign operation_code = r_op;

  // --------------------------------------------------------------------- boost
`ifdef OPERATION_ENCODER_BOOST_EN
  localparam int c_TMAX = (BOOST_CYCLES > COOLDOWN_CYCLES) ? BOOST_CYCLES : COOLDOWN_CYCLES;
  localparam int c_TW   = $clog2(c_TMAX + 1);
  localparam logic [c_TW-1:0] c_ACT_LAST = c_TW'(BOOST_CYCLES - 1);
  localparam logic [c_TW-1:0] c_CD_LAST  = c_TW'(COOLDOWN_CYCLES - 1);

  logic            w_boost_lvl;
  logic            r_boost_prev;
  logic            w_boost_rise;
  logic [1:0]      r_fsm;
  logic [1:0]      w_fsm_next;
  logic [c_TW-1:0] r_timer;
  logic [c_TW-1:0] w_timer_next;
  logic [c_TW-1:0] w_timer_inc;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_boost (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn_boost),
    .level(w_boost_lvl)
  );

  assign w_boost_rise = w_boost_lvl & ~r_boost_prev;
  // Saturating increment: the timer never wraps.
  assign w_timer_inc  = (r_timer == {c_TW{1'b1}}) ? r_timer : r_timer + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_boost_prev <= 1'b0;
      r_fsm        <= c_BST_READY;
      r_timer      <= '0;
    end else begin
      r_boost_prev <= w_boost_lvl;
      r_fsm        <= w_fsm_next;
      r_timer      <= w_timer_next;
    end
  end

  // Only RACING cycles advance the timer; PAUSE freezes everything; any other
  // game state drops back to READY. Edges seen outside READY are discarded.
  always_comb begin
    w_fsm_next   = r_fsm;
    w_timer_next = r_timer;
    if (state == c_ST_RACING) begin
      case (r_fsm)
        c_BST_READY: begin
          if (w_boost_rise) begin
            w_fsm_next   = c_BST_ACTIVE;
            w_timer_next = '0;
          end
        end
        c_BST_ACTIVE: begin
          if (r_timer == c_ACT_LAST) begin
            w_fsm_next   = c_BST_COOLDOWN;
            w_timer_next = '0;
          end else begin
            w_timer_next = w_timer_inc;
          end
        end
        c_BST_COOLDOWN: begin
          if (r_timer == c_CD_LAST) begin
            w_fsm_next   = c_BST_READY;
            w_timer_next = '0;
          end else begin
            w_timer_next = w_timer_inc;
          end
        end
        default: begin
          w_fsm_next   = c_BST_READY;
          w_timer_next = '0;
        end
      endcase
    end else if (state != c_ST_PAUSE) begin
      w_fsm_next   = c_BST_READY;
      w_timer_next = '0;
    end
  end

  always_comb begin
    boost       = (r_fsm == c_BST_ACTIVE) && (state == c_ST_RACING);
    boost_ready = (r_fsm == c_BST_READY);
  end
`else
  localparam int c_unused_cfg = BOOST_CYCLES + COOLDOWN_CYCLES;
  logic w_unused_boost;
  assign w_unused_boost = btn_boost;
  assign boost          = 1'b0;
  assign boost_ready    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_operation_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_operation_encoder
// Purpose  : Scoreboard bench for operation_encoder. Stimulus pushes the
//            expected outputs for a given clock edge into a queue; a monitor
//            on the falling edge pops and compares entries due at that edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_operation_encoder;

`ifdef OPERATION_ENCODER_BOOST_EN
  localparam bit BEN = 1'b1;
`else
  localparam bit BEN = 1'b0;
`endif

  localparam logic [2:0] NIL = 3'd0, FWD = 3'd1, BWD = 3'd2, LFT = 3'd3, RGT = 3'd4;
  localparam logic [2:0] RACING = 3'd4, PAUSE = 3'd5, FINISH = 3'd6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic       btn_boost = 1'b0;
  logic [2:0] state = 3'd4;
  logic [2:0] operation_code;
  logic       boost;
  logic       boost_ready;

  operation_encoder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_up        (btn_up),
    .btn_down      (btn_down),
    .btn_left      (btn_left),
    .btn_right     (btn_right),
    .btn_boost     (btn_boost),
    .state         (state),
    .operation_code(operation_code),
    .boost         (boost),
    .boost_ready   (boost_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at;
    logic [2:0] op;
    logic       bst;
    logic       rdy;
    string      nm;
  } exp_t;

  exp_t sb[$];
  int   edge_n = 0;
  int   total  = 0;
  int   bad    = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Boost expectations are written as for an enabled boost path and masked
  // to zero when the path is configured out.
  function automatic void expect_at(input int at, input logic [2:0] op,
                                    input logic bst, input logic rdy, input string nm);
    exp_t e;
    e.at  = at;
    e.op  = op;
    e.bst = bst & BEN;
    e.rdy = rdy & BEN;
    e.nm  = nm;
    sb.push_back(e);
  endfunction

  task automatic cmp(input string nm, input string fld, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s.%s at edge %0d: got %0d, expected %0d", nm, fld, edge_n, act, exp);
    end
  endtask

  // Monitor: compare every entry due at the current edge count.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].at <= edge_n) begin
      e = sb.pop_front();
      if (e.at < edge_n) begin
        total++;
        bad++;
        $display("FAIL %s missed: due edge %0d, now %0d", e.nm, e.at, edge_n);
      end else begin
        cmp(e.nm, "op", int'(operation_code), int'(e.op));
        cmp(e.nm, "boost", int'(boost), int'(e.bst));
        cmp(e.nm, "ready", int'(boost_ready), int'(e.rdy));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m, p, q, s, r;
    // Reset state
    step(1);
    expect_at(edge_n, NIL, 0, 1, "reset0");
    expect_at(edge_n + 1, NIL, 0, 1, "reset1");
    step(3);
    rst_n = 1'b1;
    step(2);

    // Press latency: 19 edges
    n = edge_n;
    expect_at(n + 18, NIL, 0, 1, "up_lat18");
    expect_at(n + 19, FWD, 0, 1, "up_lat19");
    btn_up = 1'b1;
    step(25);
    n = edge_n;
    expect_at(n + 18, FWD, 0, 1, "up_rel18");
    expect_at(n + 19, NIL, 0, 1, "up_rel19");
    btn_up = 1'b0;
    step(25);

    // 10-cycle glitch is filtered
    n = edge_n;
    expect_at(n + 5, NIL, 0, 1, "glitch5");
    expect_at(n + 15, NIL, 0, 1, "glitch15");
    expect_at(n + 25, NIL, 0, 1, "glitch25");
    expect_at(n + 32, NIL, 0, 1, "glitch32");
    btn_up = 1'b1;
    step(10);
    btn_up = 1'b0;
    step(35);

    // up held, left pressed then released
    n = edge_n;
    expect_at(n + 19, FWD, 0, 1, "ul_fwd");
    btn_up = 1'b1;
    step(25);
    m = edge_n;
    expect_at(m + 18, FWD, 0, 1, "ul_fwd2");
    expect_at(m + 19, LFT, 0, 1, "ul_left");
    btn_left = 1'b1;
    step(25);
    m = edge_n;
    expect_at(m + 18, LFT, 0, 1, "ul_left2");
    expect_at(m + 19, FWD, 0, 1, "ul_back_fwd");
    btn_left = 1'b0;
    step(25);
    expect_at(edge_n + 19, NIL, 0, 1, "ul_nil");
    btn_up = 1'b0;
    step(25);

    // Simultaneous press: priority, then fallback on release
    n = edge_n;
    expect_at(n + 18, NIL, 0, 1, "sim18");
    expect_at(n + 19, BWD, 0, 1, "sim_bwd");
    btn_down = 1'b1; btn_left = 1'b1; btn_right = 1'b1;
    step(25);
    m = edge_n;
    expect_at(m + 18, BWD, 0, 1, "sim_bwd2");
    expect_at(m + 19, LFT, 0, 1, "sim_fallback_left");
    btn_down = 1'b0;
    step(25);
    expect_at(edge_n + 19, NIL, 0, 1, "sim_nil");
    btn_left = 1'b0; btn_right = 1'b0;
    step(25);

    // Most recent beats priority; state gating; tracker runs while paused
    expect_at(edge_n + 19, BWD, 0, 1, "rec_bwd");
    btn_down = 1'b1;
    step(25);
    m = edge_n;
    expect_at(m + 18, BWD, 0, 1, "rec_bwd2");
    expect_at(m + 19, RGT, 0, 1, "rec_right");
    btn_right = 1'b1;
    step(25);
    p = edge_n;
    expect_at(p, RGT, 0, 1, "gate_before");
    expect_at(p + 1, NIL, 0, 1, "gate_pause");
    state = PAUSE;
    step(5);
    q = edge_n;
    expect_at(q + 25, NIL, 0, 1, "pause_hold_nil");
    btn_right = 1'b0;
    step(25);
    s = edge_n;
    expect_at(s + 1, BWD, 0, 1, "resume_tracked_bwd");
    state = RACING;
    step(5);
    expect_at(edge_n + 19, NIL, 0, 1, "rec_nil");
    btn_down = 1'b0;
    step(25);

    // Boost: 64 active, 128 cooldown, press during cooldown ignored
    n = edge_n;
    expect_at(n + 18, NIL, 0, 1, "b_pre");
    expect_at(n + 19, NIL, 1, 0, "b_start");
    expect_at(n + 50, NIL, 1, 0, "b_mid");
    expect_at(n + 82, NIL, 1, 0, "b_last");
    expect_at(n + 83, NIL, 0, 0, "b_cd_start");
    expect_at(n + 150, NIL, 0, 0, "b_cd_press_ignored");
    expect_at(n + 210, NIL, 0, 0, "b_cd_last");
    expect_at(n + 211, NIL, 0, 1, "b_rearm");
    expect_at(n + 220, NIL, 0, 1, "b_no_queue");
    btn_boost = 1'b1;
    step(30);
    btn_boost = 1'b0;
    step(70);
    btn_boost = 1'b1;
    step(30);
    btn_boost = 1'b0;
    step(95);

    // Boost with a 50-cycle pause, then FINISH during cooldown
    n = edge_n;
    expect_at(n + 19, NIL, 1, 0, "p_start");
    expect_at(n + 28, NIL, 1, 0, "p_before");
    expect_at(n + 29, NIL, 0, 0, "p_paused");
    expect_at(n + 60, NIL, 0, 0, "p_paused_mid");
    expect_at(n + 79, NIL, 1, 0, "p_resumed");
    expect_at(n + 132, NIL, 1, 0, "p_last");
    expect_at(n + 133, NIL, 0, 0, "p_cd");
    expect_at(n + 140, NIL, 0, 0, "p_cd2");
    btn_boost = 1'b1;
    step(29);
    state = PAUSE;
    step(1);
    btn_boost = 1'b0;
    step(49);
    state = RACING;
    step(61);
    expect_at(edge_n + 1, NIL, 0, 1, "finish_cd_ready");
    state = FINISH;
    step(5);
    state = RACING;
    step(5);

    // FINISH mid-boost
    m = edge_n;
    expect_at(m + 18, NIL, 0, 1, "f_pre");
    expect_at(m + 19, NIL, 1, 0, "f_start");
    expect_at(m + 29, NIL, 1, 0, "f_active");
    expect_at(m + 30, NIL, 0, 0, "f_finish");
    expect_at(m + 31, NIL, 0, 1, "f_ready");
    btn_boost = 1'b1;
    step(30);
    state = FINISH;
    step(5);
    btn_boost = 1'b0;
    step(5);
    state = RACING;
    step(20);

    // Asynchronous reset mid-boost with buttons held
    m = edge_n;
    expect_at(m + 39, FWD, 1, 0, "ar_before");
    expect_at(m + 40, NIL, 0, 1, "ar_async");
    btn_up = 1'b1;
    btn_boost = 1'b1;
    step(40);
    rst_n = 1'b0;
    expect_at(edge_n + 1, NIL, 0, 1, "ar_hold");
    step(3);
    rst_n = 1'b1;
    r = edge_n;
    expect_at(r + 18, NIL, 0, 1, "ar_post18");
    expect_at(r + 19, FWD, 1, 0, "ar_post19");
    expect_at(r + 30, FWD, 1, 0, "ar_post30");
    step(35);
    btn_up = 1'b0;
    btn_boost = 1'b0;
    step(5);

    for (int i = 0; i < 200 && sb.size() > 0; i++) step(1);
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations never checked", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
